// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the instruction fetch stage
// RV32 base opcodes and instruction field bit positions.
package fetch_pkg;

  localparam int ILEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int IMM_LSB    = 7;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched {pc, word} entries
// Flush has priority over push/pop; the head reads as zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential-PC instruction fetch with queued, pre-split output
// Tracks outstanding fetches and discards responses orphaned by a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_word,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      inst_opcode,
  output logic [4:0]      inst_rd,
  output logic [2:0]      inst_funct3,
  output logic [4:0]      inst_rs1,
  output logic [4:0]      inst_rs2,
  output logic [6:0]      inst_funct7,
  output logic [24:0]     inst_imm_raw
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Drops are not bounded by DEPTH: new fetches may issue while old ones drain.
  localparam int DW = CW + 4;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [DW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       inflight;
  logic [2*XLEN-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              req_fire, rsp_drop, rsp_take, pop;

  assign inflight      = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign mem_req_valid = reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_drop      = mem_rsp_valid && (drop_q != '0);
  assign rsp_take      = mem_rsp_valid && (drop_q == '0) && (outstanding_q != '0);
  assign pop           = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc;
      rsp_pc_d      = redirect_pc;
      outstanding_d = '0;
      drop_d        = drop_q - DW'(rsp_drop) + DW'(outstanding_q) - DW'(rsp_take);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_take) rsp_pc_d   = rsp_pc_q + XLEN'(4);
      if (rsp_drop) drop_d     = drop_q - DW'(1);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH(2*XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (rsp_take && !redirect_valid),
    .data_i  ({rsp_pc_q, mem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign inst_valid   = !fifo_empty;
  assign inst_word    = fifo_head[XLEN-1:0];
  assign inst_pc      = fifo_head[2*XLEN-1:XLEN];
  assign inst_opcode  = inst_word[OPCODE_LSB +: 7];
  assign inst_rd      = inst_word[RD_LSB +: 5];
  assign inst_funct3  = inst_word[FUNCT3_LSB +: 3];
  assign inst_rs1     = inst_word[RS1_LSB +: 5];
  assign inst_rs2     = inst_word[RS2_LSB +: 5];
  assign inst_funct7  = inst_word[FUNCT7_LSB +: 7];
  assign inst_imm_raw = inst_word[IMM_LSB +: 25];

  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rsp_valid && outstanding_q == '0 && drop_q == '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(fifo_full && rsp_take && !pop && !redirect_valid));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_word, inst_pc;
  logic [6:0]  inst_opcode, inst_funct7;
  logic [4:0]  inst_rd, inst_rs1, inst_rs2;
  logic [2:0]  inst_funct3;
  logic [24:0] inst_imm_raw;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word), .inst_pc(inst_pc),
    .inst_opcode(inst_opcode), .inst_rd(inst_rd), .inst_funct3(inst_funct3), .inst_rs1(inst_rs1),
    .inst_rs2(inst_rs2), .inst_funct7(inst_funct7), .inst_imm_raw(inst_imm_raw)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] issued[$];
  int          cyc = 0, lat = 1, pops = 0;
  int          checks = 0, errors = 0;
  logic        stall_valid = 1'b0;
  logic [31:0] stall_addr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h00A28293 ^ (a << 20);
  endfunction

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory: in-order responses, each presented lat cycles after its handshake.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  // Request side: handshake sampling, expected-entry push, stall stability.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      pend.delete();
      exp_q.delete();
      stall_valid = 1'b0;
    end else begin
      if (stall_valid && mem_req_valid)
        chk("req_addr_stable", mem_req_addr == stall_addr, mem_req_addr, stall_addr);
      stall_valid = mem_req_valid && !mem_req_ready;
      stall_addr  = mem_req_addr;
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{mem_req_addr, cyc + lat});
        issued.push_back(mem_req_addr);
        exp_q.push_back('{mem_req_addr, word_of(mem_req_addr)});
        chk("inflight_le_depth", exp_q.size() <= DEPTH, exp_q.size(), DEPTH);
      end
    end
  end

  // Monitor: compares every consumed instruction against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      if (redirect_valid) begin
        exp_q.delete();
      end else if (inst_valid && inst_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1'b0, inst_pc, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", inst_pc == e.pc, inst_pc, e.pc);
          chk("pop_word", inst_word == e.w, inst_word, e.w);
          chk("pop_fields", {inst_funct7, inst_rs2, inst_rs1, inst_funct3, inst_rd, inst_opcode} == e.w,
              {inst_funct7, inst_rs2, inst_rs1, inst_funct3, inst_rd, inst_opcode}, e.w);
          chk("pop_imm_raw", inst_imm_raw == e.w[31:7], inst_imm_raw, e.w[31:7]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=%0d required=done", cyc);
    $fatal(1);
  end

  initial begin
    int p0;
    bit found;
    logic [31:0] rdy_pat, ir_pat;
    reset = 1'b0; mem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(2);
    #3;
    chk("rst_inst_valid", inst_valid == 1'b0, inst_valid, 0);
    chk("rst_req_valid", mem_req_valid == 1'b0, mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr == RESET_PC, mem_req_addr, RESET_PC);
    chk("rst_inst_word", inst_word == 32'h0, inst_word, 0);

    // 1: fill to DEPTH with decode stalled
    tick(1);
    reset = 1'b1; mem_req_ready = 1'b1; lat = 1;
    tick(10);
    #3;
    chk("t1_issued_n", issued.size() == 4, issued.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < issued.size()) chk("t1_addr", issued[i] == 32'(i * 4), issued[i], i * 4);
    chk("t1_req_stop", mem_req_valid == 1'b0, mem_req_valid, 0);
    chk("t1_valid", inst_valid == 1'b1, inst_valid, 1);
    chk("t1_pc", inst_pc == 32'h0, inst_pc, 0);
    chk("t1_word", inst_word == 32'h00A28293, inst_word, 32'h00A28293);
    chk("t1_opcode", inst_opcode == 7'h13, inst_opcode, 7'h13);
    chk("t1_rd", inst_rd == 5'd5, inst_rd, 5);
    chk("t1_rs1", inst_rs1 == 5'd5, inst_rs1, 5);
    chk("t1_funct3", inst_funct3 == 3'd0, inst_funct3, 0);
    chk("t1_rs2_imm", inst_rs2 == 5'd10, inst_rs2, 10);
    chk("t1_funct7", inst_funct7 == 7'd0, inst_funct7, 0);
    chk("t1_imm_raw", inst_imm_raw == 25'h0014505, inst_imm_raw, 25'h0014505);

    // 2: steady stream, one instruction per cycle
    tick(1);
    inst_ready = 1'b1;
    p0 = pops;
    tick(16);
    chk("t2_rate", (pops - p0) == 16, pops - p0, 16);

    // 3: redirect with two fetches outstanding
    mem_req_ready = 1'b0;
    tick(8);
    lat = 6; mem_req_ready = 1'b1;
    tick(2);
    mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    #3;
    chk("t3_outstanding", pend.size() == 2, pend.size(), 2);
    tick(1);
    redirect_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    chk("t3_flushed", inst_valid == 1'b0, inst_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (inst_valid) found = 1'b1;
    end
    chk("t3_wait", found, found, 1);
    if (found) chk("t3_first_pc", inst_pc == 32'h100, inst_pc, 32'h100);

    // 4: redirect coinciding with a counted response and a pop
    lat = 1;
    tick(12);
    chk("t4_setup", mem_rsp_valid && inst_valid, {mem_rsp_valid, inst_valid}, 2'b11);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", inst_valid == 1'b0, inst_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (inst_valid) found = 1'b1;
    end
    chk("t4_wait", found, found, 1);
    if (found) chk("t4_first_pc", inst_pc == 32'h200, inst_pc, 32'h200);

    // 5: memory stalls and decode backpressure
    tick(1);
    lat = 2;
    rdy_pat = 32'b1011_0010_1110_0100_0111_1001_0010_1101;
    ir_pat  = 32'b0110_1101_0011_1010_1100_0101_1110_0011;
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      mem_req_ready = rdy_pat[i % 32];
      inst_ready    = ir_pat[(i * 7) % 32];
      tick(1);
    end
    chk("t5_progress", (pops - p0) > 10, pops - p0, 11);

    // 6: reset mid-stream with the queue full
    mem_req_ready = 1'b1; inst_ready = 1'b0; lat = 1;
    tick(12);
    chk("t6_full", inst_valid && !mem_req_valid, {inst_valid, mem_req_valid}, 2'b10);
    reset = 1'b0;
    #1;
    chk("t6_inst_valid", inst_valid == 1'b0, inst_valid, 0);
    chk("t6_inst_word", inst_word == 32'h0, inst_word, 0);
    chk("t6_inst_pc", inst_pc == 32'h0, inst_pc, 0);
    chk("t6_inst_imm", inst_imm_raw == 25'h0, inst_imm_raw, 0);
    chk("t6_req_valid", mem_req_valid == 1'b0, mem_req_valid, 0);
    chk("t6_req_addr", mem_req_addr == RESET_PC, mem_req_addr, RESET_PC);
    tick(2);
    issued.delete();
    reset = 1'b1; inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (inst_valid) found = 1'b1;
    end
    chk("t6_wait", found, found, 1);
    if (found) chk("t6_first_pc", inst_pc == RESET_PC, inst_pc, RESET_PC);
    if (issued.size() > 0) chk("t6_first_addr", issued[0] == RESET_PC, issued[0], RESET_PC);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
